frame_ram_arbiter: RTL and testbench

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

---
 rtl/frame_ram_pkg.sv | 31 +++
 rtl/frame_ram_arbiter_if.sv | 50 +++++
 rtl/ram_wr_fifo.sv | 88 ++++++++
 rtl/frame_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_ram_pkg.sv
// -----------------------------------------------------------------------------
// frame_ram_pkg
// Shared definitions for the frame RAM arbiter slice.
//   FR_ADDR_W / FR_DATA_W / FR_WFIFO_DEPTH : default geometry
//   grant_t     : per-cycle RAM port owner (IDLE, READ, WRITE)
//   arb_state_t : arbiter mode (NORMAL, FLUSH)
//   lvl_width() : bit width needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package frame_ram_pkg;

   localparam int FR_ADDR_W      = 16;
   localparam int FR_DATA_W      = 16;
   localparam int FR_WFIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } grant_t;

   typedef enum logic {
      NORMAL = 1'b0,
      FLUSH  = 1'b1
   } arb_state_t;

   // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// frame_ram_arbiter_if
// Bundles the receiver write port, display read port, flush handshake and the
// single-port RAM bus of the frame RAM arbiter.
//   slave  modport : seen by the arbiter
//   master modport : seen by the environment (receiver, display, RAM)
// -----------------------------------------------------------------------------
interface frame_ram_arbiter_if #(
   parameter int ADDR_W      = frame_ram_pkg::FR_ADDR_W,
   parameter int DATA_W      = frame_ram_pkg::FR_DATA_W,
   parameter int WFIFO_DEPTH = frame_ram_pkg::FR_WFIFO_DEPTH
);
   import frame_ram_pkg::*;

   localparam int LVL_W = lvl_width(WFIFO_DEPTH);

   // receiver side
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   // display side
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   // flush / status
   logic              flush_req;
   logic              flush_done;
   logic [LVL_W-1:0]  wfifo_level;
   // RAM port
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_req, rd_addr, flush_req, ram_rdata,
      output rd_ready, rd_valid, rd_data, flush_done, wfifo_level,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output wr_en, wr_addr, wr_data, rd_req, rd_addr, flush_req, ram_rdata,
      input  rd_ready, rd_valid, rd_data, flush_done, wfifo_level,
             ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_wr_fifo.sv
// -----------------------------------------------------------------------------
// ram_wr_fifo
// Synchronous write-buffer FIFO with first-word fall-through head.
//   Clk, Reset   : clock, synchronous active-high reset
//   push_i       : enqueue push_data_i
//   pop_i        : dequeue head_o (ignored when empty)
//   head_o       : oldest entry
//   full_o/empty_o/level_o : occupancy status (level 0..DEPTH)
// A push while full is accepted only together with a pop.
// -----------------------------------------------------------------------------
module ram_wr_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   // Next pointers and occupancy; DEPTH is a power of two so pointers wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; cleared on reset so stale pixels never reappear.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// frame_ram_arbiter
// Shares one single-port frame RAM between a never-stalled pixel writer
// (buffered in ram_wr_fifo) and a display reader.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : frame_ram_arbiter_if.slave
//                write port  wr_en/wr_addr/wr_data
//                read port   rd_req/rd_addr -> rd_ready, rd_valid/rd_data
//                flush       flush_req -> flush_done, wfifo_level
//                RAM         ram_en/ram_we/ram_addr/ram_wdata, ram_rdata
// Grant priority each cycle: full FIFO drain, then read, then FIFO drain.
// RAM controls are registered, so a grant shows on ram_* one cycle later and
// read data (1-cycle RAM latency) returns two cycles after acceptance.
// -----------------------------------------------------------------------------
module frame_ram_arbiter
   import frame_ram_pkg::*;
#(
   parameter int ADDR_W      = FR_ADDR_W,
   parameter int DATA_W      = FR_DATA_W,
   parameter int WFIFO_DEPTH = FR_WFIFO_DEPTH
) (
   input  logic                 Clk,
   input  logic                 Reset,
   frame_ram_arbiter_if.slave   bus
);
   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int LVL_W   = lvl_width(WFIFO_DEPTH);

   grant_t             grant_s;
   arb_state_t         state_q, state_d;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic               pop_s;
   logic               rd_ready_s;
   logic [ENTRY_W-1:0] head_s;
   logic [ADDR_W-1:0]  head_addr_s;
   logic [DATA_W-1:0]  head_data_s;
   logic [LVL_W-1:0]   level_s;

   logic               ram_en_q, ram_en_d;
   logic               ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
   logic               rd_pend_q;
   logic               rd_valid_q;
   logic               flush_done_q, flush_done_d;

   ram_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (WFIFO_DEPTH)
   ) u_wr_fifo (
      .Clk         (Clk),
      .Reset       (Reset),
      .push_i      (bus.wr_en),
      .push_data_i ({bus.wr_addr, bus.wr_data}),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .level_o     (level_s)
   );

   assign head_addr_s = head_s[ENTRY_W-1 -: ADDR_W];
   assign head_data_s = head_s[DATA_W-1:0];

   // Reads are refused while flushing or when the buffer must drain.
   assign rd_ready_s = (state_q == NORMAL) && !fifo_full_s;
   assign pop_s      = (grant_s == WRITE);

   // Per-cycle grant of the RAM port.
   always_comb begin
      grant_s = IDLE;
      if (fifo_full_s) begin
         grant_s = WRITE;
      end else if (bus.rd_req && rd_ready_s) begin
         grant_s = READ;
      end else if (!fifo_empty_s) begin
         grant_s = WRITE;
      end else begin
         grant_s = IDLE;
      end
   end

   // Next values of the registered RAM controls; address/data hold when idle.
   always_comb begin
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      case (grant_s)
         READ: begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.rd_addr;
         end
         WRITE: begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = head_addr_s;
            ram_wdata_d = head_data_s;
         end
         default: begin
            ram_en_d = 1'b0;
            ram_we_d = 1'b0;
         end
      endcase
   end

   // Flush FSM: a flush with nothing buffered completes without entering FLUSH.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      case (state_q)
         NORMAL: begin
            if (bus.flush_req) begin
               if (fifo_empty_s && !bus.wr_en) begin
                  flush_done_d = 1'b1;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               state_d = NORMAL;
            end
         end
         FLUSH: begin
            if (fifo_empty_s && !bus.wr_en) begin
               state_d      = NORMAL;
               flush_done_d = 1'b1;
            end else begin
               state_d = FLUSH;
            end
         end
         default: begin
            state_d = NORMAL;
         end
      endcase
   end

   // State, RAM control and read-return pipeline registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= NORMAL;
         flush_done_q <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         rd_pend_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_done_q <= flush_done_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         rd_pend_q    <= (grant_s == READ);
         rd_valid_q   <= rd_pend_q;
      end
   end

   assign bus.rd_ready    = rd_ready_s;
   assign bus.rd_valid    = rd_valid_q;
   // RAM output is already registered; gate it so idle cycles show zero.
   assign bus.rd_data     = rd_valid_q ? bus.ram_rdata : '0;
   assign bus.flush_done  = flush_done_q;
   assign bus.wfifo_level = level_s;
   assign bus.ram_en      = ram_en_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_ram_arbiter
// Directed bench for frame_ram_arbiter with a behavioural single-port RAM.
// Inputs change and outputs are sampled on the falling clock edge.
// Unwritten low addresses (< 0x0010) read back as 0xA000 + address.
// -----------------------------------------------------------------------------
module tb_frame_ram_arbiter;

   logic Clk;
   logic Reset;
   int   errors;
   int   checks;

   logic [15:0] mem [256];

   frame_ram_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WFIFO_DEPTH(4)) bus ();

   frame_ram_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .WFIFO_DEPTH (4)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Single-port RAM with one cycle of read latency.
   always @(posedge Clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
         end else if (bus.ram_addr < 16'h0010) begin
            bus.ram_rdata <= 16'hA000 + bus.ram_addr;
         end else begin
            bus.ram_rdata <= mem[bus.ram_addr[7:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                        input logic rq, input logic [15:0] ra, input logic fl);
      bus.wr_en     = we;
      bus.wr_addr   = wa;
      bus.wr_data   = wd;
      bus.rd_req    = rq;
      bus.rd_addr   = ra;
      bus.flush_req = fl;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      bus.ram_rdata = 16'h0000;
      Reset = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      repeat (3) @(negedge Clk);

      // ---- reset state ----
      chk("rst_ram_en",     32'(bus.ram_en),      32'h0);
      chk("rst_ram_we",     32'(bus.ram_we),      32'h0);
      chk("rst_ram_addr",   32'(bus.ram_addr),    32'h0);
      chk("rst_ram_wdata",  32'(bus.ram_wdata),   32'h0);
      chk("rst_rd_valid",   32'(bus.rd_valid),    32'h0);
      chk("rst_flush_done", 32'(bus.flush_done),  32'h0);
      chk("rst_level",      32'(bus.wfifo_level), 32'h0);
      chk("rst_rd_ready",   32'(bus.rd_ready),    32'h1);
      Reset = 1'b0;
      @(negedge Clk);

      // ---- single write reaches RAM two cycles later ----
      drive(1'b1, 16'h0010, 16'hF800, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("w1_level1", 32'(bus.wfifo_level), 32'h1);
      chk("w1_we_early", 32'(bus.ram_we), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("w1_ram_en",   32'(bus.ram_en),      32'h1);
      chk("w1_ram_we",   32'(bus.ram_we),      32'h1);
      chk("w1_addr",     32'(bus.ram_addr),    32'h0010);
      chk("w1_wdata",    32'(bus.ram_wdata),   32'hF800);
      chk("w1_level0",   32'(bus.wfifo_level), 32'h0);
      @(negedge Clk);
      chk("w1_idle", 32'(bus.ram_en), 32'h0);

      // ---- three back-to-back reads ----
      chk("rd_ready", 32'(bus.rd_ready), 32'h1);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0);
      @(negedge Clk);
      chk("rd0_ram_en",  32'(bus.ram_en),   32'h1);
      chk("rd0_ram_we",  32'(bus.ram_we),   32'h0);
      chk("rd0_addr",    32'(bus.ram_addr), 32'h0000);
      chk("rd_valid_t1", 32'(bus.rd_valid), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0001, 1'b0);
      @(negedge Clk);
      chk("rd0_valid", 32'(bus.rd_valid), 32'h1);
      chk("rd0_data",  32'(bus.rd_data),  32'hA000);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0002, 1'b0);
      @(negedge Clk);
      chk("rd1_valid", 32'(bus.rd_valid), 32'h1);
      chk("rd1_data",  32'(bus.rd_data),  32'hA001);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("rd2_valid", 32'(bus.rd_valid), 32'h1);
      chk("rd2_data",  32'(bus.rd_data),  32'hA002);
      @(negedge Clk);
      chk("rd_valid_end", 32'(bus.rd_valid), 32'h0);

      // ---- continuous reads, five writes: fill, drain while full ----
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h0020 + 16'(i), 16'h1000 + 16'(i), 1'b1, 16'h0003, 1'b0);
         @(negedge Clk);
         chk("full_level",    32'(bus.wfifo_level), (i < 4) ? 32'(i + 1) : 32'h4);
         chk("full_rd_ready", 32'(bus.rd_ready),    (i < 3) ? 32'h1 : 32'h0);
      end
      chk("full_we0",   32'(bus.ram_we),    32'h1);
      chk("full_addr0", 32'(bus.ram_addr),  32'h0020);
      chk("full_data0", 32'(bus.ram_wdata), 32'h1000);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 1'b0);
      @(negedge Clk);
      chk("full_we1",    32'(bus.ram_we),      32'h1);
      chk("full_addr1",  32'(bus.ram_addr),    32'h0021);
      chk("full_data1",  32'(bus.ram_wdata),   32'h1001);
      chk("full_lvl3",   32'(bus.wfifo_level), 32'h3);
      chk("full_rdy_back", 32'(bus.rd_ready),  32'h1);
      @(negedge Clk);
      chk("full_read_en", 32'(bus.ram_en), 32'h1);
      chk("full_read_we", 32'(bus.ram_we), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(negedge Clk);
         chk("drain_we",    32'(bus.ram_we),      32'h1);
         chk("drain_addr",  32'(bus.ram_addr),    32'h0022 + 32'(j));
         chk("drain_data",  32'(bus.ram_wdata),   32'h1002 + 32'(j));
         chk("drain_level", 32'(bus.wfifo_level), 32'h2 - 32'(j));
      end
      @(negedge Clk);
      chk("drain_idle", 32'(bus.ram_en), 32'h0);

      // ---- flush with three buffered writes ----
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0030 + 16'(i), 16'h2000 + 16'(i), 1'b1, 16'h0004, 1'b0);
         @(negedge Clk);
         chk("fl_fill_level", 32'(bus.wfifo_level), 32'(i + 1));
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0004, 1'b1);
      @(negedge Clk);
      chk("fl_rd_ready0", 32'(bus.rd_ready),    32'h0);
      chk("fl_level3",    32'(bus.wfifo_level), 32'h3);
      @(negedge Clk);
      chk("fl_we0",   32'(bus.ram_we),    32'h1);
      chk("fl_addr0", 32'(bus.ram_addr),  32'h0030);
      chk("fl_data0", 32'(bus.ram_wdata), 32'h2000);
      chk("fl_rdy1",  32'(bus.rd_ready),  32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0004, 1'b0);
      @(negedge Clk);
      chk("fl_addr1", 32'(bus.ram_addr), 32'h0031);
      chk("fl_done_early0", 32'(bus.flush_done), 32'h0);
      @(negedge Clk);
      chk("fl_we2",   32'(bus.ram_we),      32'h1);
      chk("fl_addr2", 32'(bus.ram_addr),    32'h0032);
      chk("fl_lvl0",  32'(bus.wfifo_level), 32'h0);
      chk("fl_done_early1", 32'(bus.flush_done), 32'h0);
      @(negedge Clk);
      chk("fl_done",     32'(bus.flush_done), 32'h1);
      chk("fl_normal",   32'(bus.rd_ready),   32'h1);
      chk("fl_idle",     32'(bus.ram_en),     32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("fl_done_once", 32'(bus.flush_done), 32'h0);

      // ---- flush with an empty buffer completes next cycle ----
      @(negedge Clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
      @(negedge Clk);
      chk("efl_done",  32'(bus.flush_done), 32'h1);
      chk("efl_ready", 32'(bus.rd_ready),   32'h1);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("efl_done_once", 32'(bus.flush_done), 32'h0);

      // ---- reset with buffered writes and reads in flight ----
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0040 + 16'(i), 16'h3000 + 16'(i), 1'b1, 16'h0005, 1'b0);
         @(negedge Clk);
         chk("mr_fill_level", 32'(bus.wfifo_level), 32'(i + 1));
      end
      Reset = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      @(negedge Clk);
      chk("mr_level",    32'(bus.wfifo_level), 32'h0);
      chk("mr_ram_en",   32'(bus.ram_en),      32'h0);
      chk("mr_rd_valid", 32'(bus.rd_valid),    32'h0);
      Reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge Clk);
         chk("mr_post_we",    32'(bus.ram_we),      32'h0);
         chk("mr_post_valid", 32'(bus.rd_valid),    32'h0);
         chk("mr_post_data",  32'(bus.rd_data),     32'h0);
         chk("mr_post_level", 32'(bus.wfifo_level), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
